// File: rtl/viterbi_pkg.sv
// viterbi_pkg: speed codes, puncture patterns/periods and FSM state shared by viterbi_punct_enc.
package viterbi_pkg;
  localparam logic [1:0] SPD_1_2 = 2'd0;
  localparam logic [1:0] SPD_2_3 = 2'd1;
  localparam logic [1:0] SPD_3_4 = 2'd2;
  localparam logic [1:0] SPD_5_6 = 2'd3;
  localparam logic [2:0] PER_1_2 = 3'd1;
  localparam logic [2:0] PER_2_3 = 3'd2;
  localparam logic [2:0] PER_3_4 = 3'd3;
  localparam logic [2:0] PER_5_6 = 3'd5;
  // Bit p of each pattern is the keep flag for phase p (bit 0 = first beat of the period).
  localparam logic [4:0] PAT_A_1_2 = 5'b00001;
  localparam logic [4:0] PAT_B_1_2 = 5'b00001;
  localparam logic [4:0] PAT_A_2_3 = 5'b00011;
  localparam logic [4:0] PAT_B_2_3 = 5'b00001;
  localparam logic [4:0] PAT_A_3_4 = 5'b00101;
  localparam logic [4:0] PAT_B_3_4 = 5'b00011;
  localparam logic [4:0] PAT_A_5_6 = 5'b10101;
  localparam logic [4:0] PAT_B_5_6 = 5'b01011;
  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;
  function automatic logic [2:0] punct_period(input logic [1:0] spd);
    return spd == SPD_2_3 ? PER_2_3 : spd == SPD_3_4 ? PER_3_4 : spd == SPD_5_6 ? PER_5_6 : PER_1_2;
  endfunction
  function automatic logic [1:0] punct_keep(input logic [1:0] spd, input logic [2:0] ph);
    logic [4:0] a;
    logic [4:0] b;
    a = spd == SPD_2_3 ? PAT_A_2_3 : spd == SPD_3_4 ? PAT_A_3_4 : spd == SPD_5_6 ? PAT_A_5_6 : PAT_A_1_2;
    b = spd == SPD_2_3 ? PAT_B_2_3 : spd == SPD_3_4 ? PAT_B_3_4 : spd == SPD_5_6 ? PAT_B_5_6 : PAT_B_1_2;
    return {b[ph], a[ph]};
  endfunction
endpackage

// File: rtl/viterbi_puncture.sv
// viterbi_puncture: selects the puncture pattern for the current phase and packs kept bits from bit 0.
module viterbi_puncture
  import viterbi_pkg::*;
#(
  parameter int P_NUM_POL = 2
) (
  input  logic [P_NUM_POL-1:0] i_bits,
  input  logic [1:0]           i_speed,
  input  logic [2:0]           i_phase,
  output logic [P_NUM_POL-1:0] o_data,
  output logic [P_NUM_POL-1:0] o_valid
);
  if (P_NUM_POL == 2) begin : g_punct
    logic [1:0] keep;
    always_comb begin
      keep = punct_keep(i_speed, i_phase);
      o_data = keep == 2'b11 ? i_bits : {1'b0, keep[0] ? i_bits[0] : i_bits[1]};
      o_valid = keep == 2'b11 ? 2'b11 : keep == 2'b00 ? 2'b00 : 2'b01;
    end
  end else begin : g_pass
    assign o_data = i_bits;
    assign o_valid = '1;
  end
endmodule

// File: rtl/viterbi_punct_enc.sv
// viterbi_punct_enc: streaming convolutional encoder with puncturing and registered output.
// Define VITERBI_PUNCT_ENC_TAIL_EN to build the TAIL state that flushes K-1 zeros after each frame.
module viterbi_punct_enc
  import viterbi_pkg::*;
#(
  parameter int                                  P_SIZE_POLINOM  = 7,
  parameter int                                  P_NUM_POL       = 2,
  parameter logic [P_NUM_POL*P_SIZE_POLINOM-1:0] P_POLINOMS      = {7'b1101101, 7'b1001111},
  parameter logic [P_SIZE_POLINOM-1:0]           P_DEFOULT_STATE = '0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_data,
  input  logic                 i_valid,
  input  logic                 i_last,
  output logic                 o_ready,
  input  logic [1:0]           i_speed,
  output logic [P_NUM_POL-1:0] o_data,
  output logic [P_NUM_POL-1:0] o_valid,
  output logic                 o_last,
  input  logic                 i_ready
);
  localparam int K = P_SIZE_POLINOM;
  localparam int N = P_NUM_POL;
  state_t state_q, state_d;
  logic [K-2:0] s_q, s_d;
  logic [2:0] phase_q, phase_d, period;
  logic [1:0] speed_q, speed_d, spd;
  logic [N-1:0] o_data_q, o_data_d, o_valid_q, o_valid_d, code, p_data, p_valid;
  logic o_last_q, o_last_d;
  logic slot, accept, tail_go, step, fin, bit_in;
  logic [K-1:0] window;
  assign slot = o_valid_q == '0 || i_ready;
  assign o_ready = i_reset && state_q != TAIL && slot;
  assign accept = i_valid && o_ready;
`ifdef VITERBI_PUNCT_ENC_TAIL_EN
  localparam state_t ST_END = TAIL;
  logic [3:0] tail_cnt_q, tail_cnt_d;
  assign tail_go = state_q == TAIL && slot;
  assign fin = tail_go && tail_cnt_q == 4'(K - 2);
  always_comb tail_cnt_d = state_q != TAIL ? 4'd0 : tail_go ? tail_cnt_q + 4'd1 : tail_cnt_q;
  always_ff @(posedge i_clk) tail_cnt_q <= !i_reset ? 4'd0 : tail_cnt_d;
`else
  localparam state_t ST_END = IDLE;
  assign tail_go = 1'b0;
  assign fin = accept && i_last;
`endif
  always_comb begin
    step = accept || tail_go;
    bit_in = accept && i_data;
    // The first beat of a frame already uses the incoming speed; later beats use the latched one.
    spd = state_q == IDLE ? i_speed : speed_q;
    period = N == 2 ? punct_period(spd) : 3'd1;
    window = {s_q, bit_in};
    code = '0;
    for (int j = 0; j < N; j++) code[j] = ^(P_POLINOMS[j*K +: K] & window);
    s_d = fin ? P_DEFOULT_STATE[K-2:0] : step ? {s_q[K-3:0], bit_in} : s_q;
    phase_d = fin ? 3'd0 : !step ? phase_q : phase_q == period - 3'd1 ? 3'd0 : phase_q + 3'd1;
    speed_d = state_q == IDLE && accept ? i_speed : speed_q;
    state_d = fin ? IDLE : accept ? (i_last ? ST_END : DATA) : state_q;
    o_data_d = !slot ? o_data_q : step ? p_data : '0;
    o_valid_d = !slot ? o_valid_q : step ? p_valid : '0;
    o_last_d = !slot ? o_last_q : fin;
  end
  viterbi_puncture #(.P_NUM_POL(N)) u_punct (
    .i_bits (code),
    .i_speed(spd),
    .i_phase(phase_q),
    .o_data (p_data),
    .o_valid(p_valid)
  );
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      s_q <= P_DEFOULT_STATE[K-2:0];
      phase_q <= 3'd0;
      speed_q <= SPD_1_2;
      o_data_q <= '0;
      o_valid_q <= '0;
      o_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      phase_q <= phase_d;
      speed_q <= speed_d;
      o_data_q <= o_data_d;
      o_valid_q <= o_valid_d;
      o_last_q <= o_last_d;
    end
  end
  assign o_data = o_data_q;
  assign o_valid = o_valid_q;
  assign o_last = o_last_q;
endmodule

// File: tb/tb_viterbi_punct_enc.sv
// tb_viterbi_punct_enc: scoreboard bench for viterbi_punct_enc (default K=7, N=2 configuration).
module tb_viterbi_punct_enc;
`ifdef VITERBI_PUNCT_ENC_TAIL_EN
  localparam int TAIL_N = 6;
`else
  localparam int TAIL_N = 0;
`endif
  localparam logic [6:0] POL0 = 7'b1001111;
  localparam logic [6:0] POL1 = 7'b1101101;
  logic clk = 1'b0, i_reset = 1'b0, i_data = 1'b0, i_valid = 1'b0, i_last = 1'b0, i_ready = 1'b1;
  logic [1:0] i_speed = 2'd0;
  logic o_ready, o_last;
  logic [1:0] o_data, o_valid;
  int checks = 0, errors = 0, nbeat = 0;
  logic [4:0] exp_q[$];
  logic [4:0] prev;
  logic hold = 1'b0, ignore = 1'b0, seen_last = 1'b0;
  logic [5:0] m_s;
  int m_ph;
  logic [1:0] m_spd;

  viterbi_punct_enc dut (
    .i_clk(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .o_ready(o_ready), .i_speed(i_speed), .o_data(o_data), .o_valid(o_valid),
    .o_last(o_last), .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] keep(input logic [1:0] spd, input int ph);
    case (spd)
      2'd1: return ph == 0 ? 2'b11 : 2'b01;
      2'd2: return ph == 0 ? 2'b11 : ph == 1 ? 2'b10 : 2'b01;
      2'd3: return ph == 0 ? 2'b11 : ph % 2 == 1 ? 2'b10 : 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  function automatic int period(input logic [1:0] spd);
    return spd == 2'd1 ? 2 : spd == 2'd2 ? 3 : spd == 2'd3 ? 5 : 1;
  endfunction

  task automatic m_push(input logic b, input logic last);
    logic c0, c1;
    logic [1:0] k;
    c0 = ^(POL0 & {m_s, b});
    c1 = ^(POL1 & {m_s, b});
    k = keep(m_spd, m_ph);
    exp_q.push_back(k == 2'b11 ? {c1, c0, 2'b11, last} : k == 2'b01 ? {1'b0, c0, 2'b01, last} : {1'b0, c1, 2'b01, last});
    m_s = {m_s[4:0], b};
    m_ph = m_ph + 1 == period(m_spd) ? 0 : m_ph + 1;
  endtask

  task automatic exp_frame(input logic [31:0] bits, input int n, input logic [1:0] spd);
    m_s = '0;
    m_ph = 0;
    m_spd = spd;
    for (int i = 0; i < n; i++) m_push(bits[n-1-i], TAIL_N == 0 && i == n - 1);
    for (int i = 0; i < TAIL_N; i++) m_push(1'b0, i == TAIL_N - 1);
  endtask

  task automatic send_beat(input logic b, input logic last);
    int t;
    t = 0;
    @(negedge clk);
    i_valid = 1'b1;
    i_data = b;
    i_last = last;
    #1;
    while (!o_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: o_ready=%b required 1", o_ready);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n, input logic [1:0] spd, input int chg, input logic [1:0] spd2);
    i_speed = spd;
    for (int i = 0; i < n; i++) begin
      if (i == chg) i_speed = spd2;
      send_beat(bits[n-1-i], i == n - 1);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic impulse();
    exp_q.push_back({2'b11, 2'b11, 1'b0});
    exp_q.push_back({2'b01, 2'b11, TAIL_N == 0});
    m_s = 6'b000010;
    m_ph = 0;
    m_spd = 2'd0;
    for (int i = 0; i < TAIL_N; i++) m_push(1'b0, i == TAIL_N - 1);
    send_frame(32'b10, 2, 2'd0, -1, 2'd0);
    drain();
  endtask

  always begin
    @(negedge clk);
    #2;
    if (!i_reset || ignore) begin
      hold = 1'b0;
      if (ignore && i_reset && o_last) seen_last = 1'b1;
    end else begin
      if (hold) begin
        checks++;
        if ({o_data, o_valid, o_last} !== prev) begin
          errors++;
          $display("FAIL hold: got %b required %b", {o_data, o_valid, o_last}, prev);
        end
      end
      if (o_valid != 2'b00 && i_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat%0d: got unexpected %b required none", nbeat, {o_data, o_valid, o_last});
        end else begin
          prev = exp_q.pop_front();
          if ({o_data, o_valid, o_last} !== prev) begin
            errors++;
            $display("FAIL beat%0d: got data/valid/last %b required %b", nbeat, {o_data, o_valid, o_last}, prev);
          end
        end
        nbeat++;
      end
      hold = o_valid != 2'b00 && !i_ready;
      prev = {o_data, o_valid, o_last};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #2;
    chk("rst_data", o_data, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_last", o_last, 0);
    chk("rst_ready", o_ready, 0);
    @(negedge clk);
    i_reset = 1'b1;
    #1;
    chk("ready_after_rst", o_ready, 1);
    impulse();
    exp_frame(32'b11001111010, 11, 2'd0);
    send_frame(32'b11001111010, 11, 2'd0, -1, 2'd0);
    drain();
    exp_frame(32'b110100111, 9, 2'd2);
    send_frame(32'b110100111, 9, 2'd2, -1, 2'd0);
    drain();
    exp_frame(32'b1011001110, 10, 2'd3);
    send_frame(32'b1011001110, 10, 2'd3, -1, 2'd0);
    drain();
    exp_frame(32'b1101001, 7, 2'd1);
    send_frame(32'b1101001, 7, 2'd1, -1, 2'd0);
    drain();
    exp_frame(32'b10110010, 8, 2'd1);
    send_frame(32'b10110010, 8, 2'd1, 3, 2'd2);
    drain();
    exp_frame(32'b101100, 6, 2'd2);
    send_frame(32'b101100, 6, 2'd2, -1, 2'd0);
    drain();
    exp_frame(32'b101101110001, 12, 2'd0);
    fork
      send_frame(32'b101101110001, 12, 2'd0, -1, 2'd0);
      begin
        repeat (5) @(negedge clk);
        i_ready = 1'b0;
        repeat (3) begin
          #1;
          chk("stall_ready", o_ready, 0);
          @(negedge clk);
        end
        i_ready = 1'b1;
      end
    join
    drain();
    ignore = 1'b1;
    seen_last = 1'b0;
    i_speed = 2'd0;
    for (int i = 0; i < 3; i++) send_beat(1'b1, TAIL_N != 0 && i == 2);
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    #2;
    chk("abort_valid", o_valid, 0);
    chk("abort_last", o_last, 0);
    chk("abort_ready", o_ready, 0);
    chk("abort_no_last", seen_last, 0);
    exp_q.delete();
    @(negedge clk);
    i_reset = 1'b1;
    ignore = 1'b0;
    impulse();
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/viterbi_punct_enc.md
VITERBI_PUNCT_ENC -- requirements
Module: viterbi_punct_enc

Interface
REQ-001 Parameter P_SIZE_POLINOM, default 7, constraint length K (3..9).
REQ-002 Parameter P_NUM_POL, default 2, number of generator polynomials N (2..4); code rate 1/N before puncturing.
REQ-003 Parameter P_POLINOMS, default {7'b1101101, 7'b1001111}, N*K bits; polynomial i in bits [i*K +: K].
REQ-004 Parameter P_DEFOULT_STATE, default 7'b0000000, K bits; encoder state after reset and at frame start.
REQ-005 One clock; reset is synchronous and active-low: i_clk input 1, rising-edge clock; i_reset input 1, synchronous active-low reset.
REQ-006 i_data input 1, information bit.
REQ-007 i_valid input 1, i_data valid.
REQ-008 i_last input 1, qualifies the final information bit of a frame.
REQ-009 o_ready output 1, block accepts a beat this cycle.
REQ-010 i_speed input 2: 0 = 1/2, 1 = 2/3, 2 = 3/4, 3 = 5/6. Only meaningful when N=2.
REQ-011 o_data output N, coded bits packed from bit 0.
REQ-012 o_valid output N, thermometer mask; o_valid[j]=1 means o_data[j] is valid.
REQ-013 o_last output 1, asserted with the final coded beat of a frame.
REQ-014 i_ready input 1, downstream accepts the output beat.

Function
REQ-015 Beat acceptance: a beat is accepted when i_valid && o_ready.
REQ-016 Coded-bit rule:
- Each information bit i is accepted on a beat.
- Coded bit c_j = XOR-reduce(P_j & {s[K-2:0], i}), with s the shift register.
- Then s <= {s[K-3:0], i}.
REQ-017 Latency: registered output; coded beat appears 1 cycle after acceptance.
REQ-018 Output hold: o_data, o_valid and o_last are held stable while o_valid!=0 and i_ready=0.
REQ-019 Ready rule: o_ready = (state != TAIL) && (o_valid==0 || i_ready); simultaneous drain and accept is allowed (full throughput).
REQ-020 Puncture patterns (N=2), per phase p, kept bits packed LSB-first:
- 1/2: c0,c1.
- 2/3: A=11, B=10.
- 3/4: A=101, B=110.
- 5/6: A=10101, B=11010.
A[p]/B[p] enable c0/c1.
REQ-021 Phase counter: advances per encoded beat and wraps at the pattern period (1, 2, 3, 5).
REQ-022 For N>2, i_speed is ignored and all N bits are always emitted.
REQ-023 Speed latch: i_speed is latched on the first accepted beat in IDLE; changes mid-frame have no effect until the next frame.
REQ-024 FSM IDLE -> DATA on an accepted beat without i_last.
REQ-025 FSM IDLE/DATA -> TAIL on an accepted beat with i_last (tail feature compiled in).
REQ-026 FSM TAIL behaviour:
- Injects K-1 zero bits, one per cycle when the output slot is free.
- Puncturing continues across tail beats.
- o_last goes with the last tail beat.
- Then returns to IDLE with s=P_DEFOULT_STATE and phase=0.
REQ-027 Single-bit frame: a frame with i_last on the first beat is legal and goes IDLE -> TAIL.

Reset
REQ-028 With i_reset=0 at a clock edge:
- state=IDLE, s=P_DEFOULT_STATE, phase=0, latched speed=0.
- o_data=0, o_valid=0, o_last=0, o_ready=0.
- o_ready=1 from the first cycle after release.
REQ-029 Reset mid-frame or mid-tail aborts the frame; no o_last is produced.

Configuration
REQ-030 With macro VITERBI_PUNCT_ENC_TAIL_EN defined, the TAIL state and zero-flush are built.
REQ-031 Without VITERBI_PUNCT_ENC_TAIL_EN:
- No TAIL state; o_last accompanies the coded beat of the i_last input.
- s and phase reset to defaults after that beat.

Structure
REQ-032 Shared package viterbi_pkg holds:
- speed encoding constants.
- puncture pattern constants and period constants.
- FSM state typedef.
REQ-033 Sub-module viterbi_puncture (combinational pattern select + LSB packing) is instantiated once.

Verification
REQ-034 Impulse, rate 1/2, zero state: inputs 1,0 -> o_data/o_valid 2'b11/2'b11, then 2'b01/2'b11.
REQ-035 Rate 3/4, continuous inputs -> o_valid sequence 11,01,01 repeating; 4 bits per 3 inputs.
REQ-036 Rate 1/2 regression: frame 11001111010 with i_last -> 11+6 beats, bit-exact with viterbi_enc (same polynomials); o_last on beat 17.
REQ-037 Backpressure: i_ready=0 for 3 cycles mid-frame -> output held stable, o_ready=0, no bit lost or duplicated.
REQ-038 Speed change mid-frame 1->2 -> pattern unchanged until next frame; next frame uses 3/4 from phase 0.
REQ-039 Reset asserted during TAIL -> outputs 0 next cycle, no o_last; new frame encodes from zero state.
